writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// writeback_queue
//   Small in-order queue of pending register-file writes. Upstream pushes
//   (addr, data) pairs; the queue drains the oldest entry to the register-file
//   write port whenever it is non-empty and not held. Pending entries are
//   searched combinationally so two read ports can pick up values that have
//   not reached the register file yet.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on occupancy (and reset), never on a same-cycle pop.
//   The drain side has no ready: wr_ena high at an edge always removes the head.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     upstream request handshake
//   in_addr, in_data      destination register index / value
//   wr_hold               stalls the drain while high
//   wr_ena/addr/data      register-file write port (oldest entry)
//   rd_addr0/1            read addresses looked up in the queue
//   byp_hit0/1, byp_data0/1  bypass results (youngest matching entry)
//   count                 number of valid entries
module writeback_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_addr,
  input  logic [N-1:0]               in_data,
  input  logic                       wr_hold,
  output logic                       wr_ena,
  output logic [4:0]                 wr_addr,
  output logic [N-1:0]               wr_data,
  input  logic [4:0]                 rd_addr0,
  input  logic [4:0]                 rd_addr1,
  output logic                       byp_hit0,
  output logic                       byp_hit1,
  output logic [N-1:0]               byp_data0,
  output logic [N-1:0]               byp_data1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [N-1:0]  data_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic not_empty;
  logic push;
  logic pop;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < CW'(DEPTH)) && !rst;
  assign wr_ena    = not_empty && !wr_hold && !rst;

  // Writes to x0 complete the handshake but are never stored.
  assign push = in_valid && in_ready && (in_addr != 5'd0);
  assign pop  = wr_ena;

  assign wr_addr = not_empty ? addr_q[rd_ptr_q] : 5'd0;
  assign wr_data = not_empty ? data_q[rd_ptr_q] : '0;
  assign count   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

  // Bypass search walks entries oldest to youngest so the last match wins,
  // giving the youngest value. Only stored entries are searched; the head
  // that is being written this cycle still counts as pending.
  logic [PW-1:0] byp_idx;

  always_comb begin
    byp_idx   = '0;
    byp_hit0  = 1'b0;
    byp_hit1  = 1'b0;
    byp_data0 = '0;
    byp_data1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      byp_idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((rd_addr0 != 5'd0) && (addr_q[byp_idx] == rd_addr0)) begin
          byp_hit0  = 1'b1;
          byp_data0 = data_q[byp_idx];
        end
        if ((rd_addr1 != 5'd0) && (addr_q[byp_idx] == rd_addr1)) begin
          byp_hit1  = 1'b1;
          byp_data1 = data_q[byp_idx];
        end
      end
    end
    if (rst) begin
      byp_hit0  = 1'b0;
      byp_hit1  = 1'b0;
      byp_data0 = '0;
      byp_data1 = '0;
    end
  end

endmodule
